// File: rtl/calc_datapath.sv
// Operand/result datapath for the calculator.
// Captures hex digits into operands A and B, latches the operation code,
// computes add/sub/and in one cycle and multiply iteratively (one bit per
// cycle), and selects the display value from the control FSM phase.
module calc_datapath #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   digit,
    input  logic [1:0]   op_sel,
    input  logic         trigger_1,
    input  logic         trigger_2,
    input  logic         trigger_op,
    input  logic         reset_a_reg,
    input  logic [2:0]   estado,
    output logic [W-1:0] disp_value,
    output logic [2:0]   count_a,
    output logic [2:0]   count_b,
    output logic         busy,
    output logic         result_valid,
    output logic         ovf
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_AND = 2'b11
    } op_e;

    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;
    logic [2:0]     r_count_a;
    logic [2:0]     r_count_b;
    op_e            r_op_reg;
    logic [W-1:0]   r_result;
    logic           r_busy;
    logic           r_result_valid;
    logic           r_ovf;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_mul_b;
    logic [CW-1:0]  r_bit_cnt;

    logic [W:0]     w_add_sum;
    logic [W-1:0]   w_sub_diff;
    logic           w_borrow;
    logic [2*W-1:0] w_mul_addend;
    logic [2*W-1:0] w_mul_sum;
    logic           w_mul_last;
    logic [W-1:0]   w_disp;

    // Arithmetic helpers: full-width add, borrow-aware subtract, one multiply step.
    always_comb begin
        w_add_sum    = {1'b0, r_op_a} + {1'b0, r_op_b};
        w_sub_diff   = r_op_a - r_op_b;
        w_borrow     = (r_op_a < r_op_b);
        if (r_mul_b[0]) begin
            w_mul_addend = {{W{1'b0}}, r_op_a} << r_bit_cnt;
        end else begin
            w_mul_addend = {(2*W){1'b0}};
        end
        w_mul_sum    = r_acc + w_mul_addend;
        w_mul_last   = (r_bit_cnt == CW'(W - 1));
    end

    // Operand entry: shift digits in until four have been taken; later digits are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_a    <= {W{1'b0}};
            r_op_b    <= {W{1'b0}};
            r_count_a <= 3'd0;
            r_count_b <= 3'd0;
        end else if (reset_a_reg) begin
            r_op_a    <= {W{1'b0}};
            r_op_b    <= {W{1'b0}};
            r_count_a <= 3'd0;
            r_count_b <= 3'd0;
        end else begin
            if (trigger_1 && (r_count_a < 3'd4)) begin
                r_op_a    <= {r_op_a[W-5:0], digit};
                r_count_a <= r_count_a + 3'd1;
            end
            if (trigger_2 && (r_count_b < 3'd4)) begin
                r_op_b    <= {r_op_b[W-5:0], digit};
                r_count_b <= r_count_b + 3'd1;
            end
        end
    end

    // Compute engine: start on trigger_op when idle, finish single-cycle ops next
    // cycle, and walk the multiplier one bit of B per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_reg       <= OP_ADD;
            r_result       <= {W{1'b0}};
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_ovf          <= 1'b0;
            r_acc          <= {(2*W){1'b0}};
            r_mul_b        <= {W{1'b0}};
            r_bit_cnt      <= {CW{1'b0}};
        end else if (reset_a_reg) begin
            r_op_reg       <= OP_ADD;
            r_result       <= {W{1'b0}};
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_ovf          <= 1'b0;
            r_acc          <= {(2*W){1'b0}};
            r_mul_b        <= {W{1'b0}};
            r_bit_cnt      <= {CW{1'b0}};
        end else if (!r_busy) begin
            if (trigger_op) begin
                r_op_reg       <= op_e'(op_sel);
                r_result_valid <= 1'b0;
                r_busy         <= 1'b1;
                r_acc          <= {(2*W){1'b0}};
                r_mul_b        <= r_op_b;
                r_bit_cnt      <= {CW{1'b0}};
            end
        end else begin
            case (r_op_reg)
                OP_ADD: begin
                    {r_ovf, r_result} <= w_add_sum;
                    r_busy            <= 1'b0;
                    r_result_valid    <= 1'b1;
                end
                OP_SUB: begin
                    r_result       <= w_sub_diff;
                    r_ovf          <= w_borrow;
                    r_busy         <= 1'b0;
                    r_result_valid <= 1'b1;
                end
                OP_AND: begin
                    r_result       <= r_op_a & r_op_b;
                    r_ovf          <= 1'b0;
                    r_busy         <= 1'b0;
                    r_result_valid <= 1'b1;
                end
                OP_MUL: begin
                    r_acc     <= w_mul_sum;
                    r_mul_b   <= r_mul_b >> 1;
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                    if (w_mul_last) begin
                        r_result       <= w_mul_sum[W-1:0];
                        r_ovf          <= |w_mul_sum[2*W-1:W];
                        r_busy         <= 1'b0;
                        r_result_valid <= 1'b1;
                    end
                end
                default: begin
                    r_result       <= {W{1'b0}};
                    r_ovf          <= 1'b0;
                    r_busy         <= 1'b0;
                    r_result_valid <= 1'b1;
                end
            endcase
        end
    end

    // Display select by FSM phase; an unfinished result shows as zero.
    always_comb begin
        w_disp = {W{1'b0}};
        case (estado)
            3'd0:    w_disp = r_op_a;
            3'd1:    w_disp = r_op_b;
            3'd2:    w_disp = {{(W-2){1'b0}}, r_op_reg};
            3'd3: begin
                if (r_result_valid) begin
                    w_disp = r_result;
                end else begin
                    w_disp = {W{1'b0}};
                end
            end
            default: w_disp = {W{1'b0}};
        endcase
    end

    assign disp_value   = w_disp;
    assign count_a      = r_count_a;
    assign count_b      = r_count_b;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign ovf          = r_ovf;

endmodule

// File: tb/tb_calc_datapath.sv
// Directed bench for calc_datapath with a queue of expected results.
module tb_calc_datapath;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   digit = 4'd0;
    logic [1:0]   op_sel = 2'd0;
    logic         trigger_1 = 1'b0;
    logic         trigger_2 = 1'b0;
    logic         trigger_op = 1'b0;
    logic         reset_a_reg = 1'b0;
    logic [2:0]   estado = 3'd0;
    logic [W-1:0] disp_value;
    logic [2:0]   count_a;
    logic [2:0]   count_b;
    logic         busy;
    logic         result_valid;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    int           m_ca = 0;
    int           m_cb = 0;
    logic [W:0]   sb[$];

    calc_datapath #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .digit        (digit),
        .op_sel       (op_sel),
        .trigger_1    (trigger_1),
        .trigger_2    (trigger_2),
        .trigger_op   (trigger_op),
        .reset_a_reg  (reset_a_reg),
        .estado       (estado),
        .disp_value   (disp_value),
        .count_a      (count_a),
        .count_b      (count_b),
        .busy         (busy),
        .result_valid (result_valid),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, result} for one operation.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
        logic [2*W-1:0] p;
        case (op)
            2'b00: model = {1'b0, a} + {1'b0, b};
            2'b01: model = {(a < b) ? 1'b1 : 1'b0, a - b};
            2'b10: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                model = {|p[2*W-1:W], p[W-1:0]};
            end
            default: model = {1'b0, a & b};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic t1, input logic t2, input logic [3:0] d);
        digit = d;
        trigger_1 = t1;
        trigger_2 = t2;
        tick();
        trigger_1 = 1'b0;
        trigger_2 = 1'b0;
        if (t1 && m_ca < 4) begin m_a = {m_a[W-5:0], d}; m_ca++; end
        if (t2 && m_cb < 4) begin m_b = {m_b[W-5:0], d}; m_cb++; end
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 3; i >= 0; i--) begin
            enter(1'b1, 1'b0, a[4*i +: 4]);
        end
        for (int i = 3; i >= 0; i--) begin
            enter(1'b0, 1'b1, b[4*i +: 4]);
        end
    endtask

    task automatic clear();
        reset_a_reg = 1'b1;
        tick();
        reset_a_reg = 1'b0;
        m_a = '0; m_b = '0; m_ca = 0; m_cb = 0;
    endtask

    // Start an op, wait for completion, compare against the queued expectation.
    task automatic run_op(input string tag, input logic [1:0] op, input int inject_at,
                          input int exp_busy);
        int cyc;
        int bc;
        logic [W:0] e;
        estado = 3'd3;
        op_sel = op;
        trigger_op = 1'b1;
        sb.push_back(model(m_a, m_b, op));
        tick();
        trigger_op = 1'b0;
        cyc = 0;
        bc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) bc++;
            if (inject_at != 0 && cyc == inject_at) begin
                op_sel = 2'b00;
                trigger_op = 1'b1;
            end else begin
                trigger_op = 1'b0;
            end
        end while (result_valid !== 1'b1 && cyc < 64);
        trigger_op = 1'b0;
        chk({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
        chk({tag, "_busy_cycles"}, bc, exp_busy);
        chk({tag, "_latency"}, cyc, exp_busy + 1);
        e = sb.pop_front();
        chk({tag, "_result"}, {16'd0, disp_value}, {16'd0, e[W-1:0]});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e[W]});
        estado = 3'd2;
        #1;
        chk({tag, "_opcode"}, {16'd0, disp_value}, {30'd0, op});
        estado = 3'd3;
    endtask

    initial begin
        // Reset state
        #3;
        for (int s = 0; s < 5; s++) begin
            estado = 3'(s);
            #1;
            chk("rst_disp", {16'd0, disp_value}, 32'd0);
        end
        chk("rst_flags", {26'd0, count_a, count_b}, 32'd0);
        chk("rst_bvo", {29'd0, busy, result_valid, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Digit entry with one-cycle latency; fifth digit dropped
        estado = 3'd0;
        enter(1'b1, 1'b0, 4'h1);
        chk("digit_latency", {16'd0, disp_value}, 32'h0001);
        for (int d = 2; d <= 5; d++) enter(1'b1, 1'b0, 4'(d));
        chk("digit_a", {16'd0, disp_value}, 32'h1234);
        chk("count_a_sat", {29'd0, count_a}, 32'd4);

        // Add with overflow, then AND recomputed on the same operands
        clear();
        load(16'hFFFF, 16'h0001);
        chk("count_b_full", {29'd0, count_b}, 32'd4);
        run_op("add_ovf", 2'b00, 0, 1);
        run_op("and_recompute", 2'b11, 0, 1);

        // Subtract with and without borrow
        clear();
        load(16'h0003, 16'h0005);
        run_op("sub_borrow", 2'b01, 0, 1);
        clear();
        load(16'h0010, 16'h0005);
        run_op("sub_plain", 2'b01, 0, 1);

        // Multiply, with an ignored trigger_op injected mid-run
        clear();
        load(16'h0123, 16'h0010);
        run_op("mul_ignore", 2'b10, 3, W);
        clear();
        load(16'h1000, 16'h0010);
        run_op("mul_ovf", 2'b10, 0, W);

        // Abort a multiply five cycles in
        clear();
        load(16'h0123, 16'h0010);
        op_sel = 2'b10;
        trigger_op = 1'b1;
        tick();
        trigger_op = 1'b0;
        repeat (4) tick();
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset_a_reg = 1'b1;
        tick();
        reset_a_reg = 1'b0;
        m_a = '0; m_b = '0; m_ca = 0; m_cb = 0;
        chk("abort_bvo", {29'd0, busy, result_valid, ovf}, 32'd0);
        chk("abort_counts", {26'd0, count_a, count_b}, 32'd0);
        for (int s = 0; s < 4; s++) begin
            estado = 3'(s);
            #1;
            chk("abort_disp", {16'd0, disp_value}, 32'd0);
        end
        repeat (20) tick();
        chk("abort_stays_idle", {30'd0, busy, result_valid}, 32'd0);

        // Simultaneous triggers, and trigger discarded by reset_a_reg
        enter(1'b1, 1'b1, 4'h7);
        estado = 3'd0; #1;
        chk("simul_a", {16'd0, disp_value}, {16'd0, m_a});
        estado = 3'd1; #1;
        chk("simul_b", {16'd0, disp_value}, {16'd0, m_b});
        chk("simul_counts", {26'd0, count_a, count_b}, {26'd0, 3'(m_ca), 3'(m_cb)});
        digit = 4'h9;
        trigger_1 = 1'b1;
        reset_a_reg = 1'b1;
        tick();
        trigger_1 = 1'b0;
        reset_a_reg = 1'b0;
        m_a = '0; m_b = '0; m_ca = 0; m_cb = 0;
        estado = 3'd0; #1;
        chk("clear_wins_a", {16'd0, disp_value}, 32'd0);
        chk("clear_wins_cnt", {29'd0, count_a}, 32'd0);

        // Asynchronous reset clears everything immediately
        load(16'h00AB, 16'h0002);
        run_op("pre_rst_add", 2'b00, 0, 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            estado = 3'(s);
            #1;
            chk("async_rst_disp", {16'd0, disp_value}, 32'd0);
        end
        chk("async_rst_bvo", {29'd0, busy, result_valid, ovf}, 32'd0);
        chk("async_rst_counts", {26'd0, count_a, count_b}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
